// File: rtl/bus_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_timer_pkg
// Brief   : Shared constants, types and helpers for the bus timer peripheral
//           and its slave handshake logic.
// Revision: 1.0 - initial release
// ============================================================================
package bus_timer_pkg;

    // Word offsets inside the 256-byte slave window
    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_PRESCALE = 8'h02;
    localparam logic [7:0] REG_RELOAD   = 8'h04;
    localparam logic [7:0] REG_COUNT    = 8'h06;
    localparam logic [7:0] REG_STATUS   = 8'h08;

    // CTRL bit positions
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

    // Slave handshake states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } ack_state_e;

    // Byte-lane merge: each strobe replaces only its own half of the word
    function automatic logic [15:0] lane_merge(
        input logic [15:0] old_v,
        input logic [15:0] new_v,
        input logic        upper,
        input logic        lower
    );
        lane_merge = {upper ? new_v[15:8] : old_v[15:8],
                      lower ? new_v[7:0]  : old_v[7:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/slave_ack_fsm.sv
`default_nettype none
// ============================================================================
// Module  : slave_ack_fsm
// Brief   : Generic strobe -> acknowledge handshake for a bus slave. Emits a
//           single-cycle commit pulse on the first strobe cycle of an access
//           and holds ack until the strobes are released.
// Revision: 1.0 - initial release
// ============================================================================
module slave_ack_fsm
    import bus_timer_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic strobe_i,
    output logic ack_o,
    output logic commit_o
);

    ack_state_e state_q;

    // Commit exactly once: only the IDLE cycle that sees the strobe
    assign commit_o = (state_q == ST_IDLE) && strobe_i;

    // Handshake state and registered acknowledge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ack_o   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (strobe_i) begin
                        state_q <= ST_ACK;
                        ack_o   <= 1'b1;
                    end
                end
                ST_ACK: begin
                    if (!strobe_i) begin
                        state_q <= ST_IDLE;
                        ack_o   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
// Module  : bus_timer
// Brief   : 16-bit prescaled down-counting timer with auto-reload or one-shot
//           mode, sticky expiry flag and level interrupt, on a byte-laned
//           CPU slave port.
// Revision: 1.0 - initial release
// ============================================================================
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [15:0] PRESCALE_RST = 16'd0,
    parameter logic [15:0] RELOAD_RST   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rw,
    input  logic [7:0]  addr,
    input  logic        uds,
    input  logic        lds,
    input  logic [15:0] write,
    output logic [15:0] read,
    output logic        ack,
    output logic        irq
);

    logic        strobe;
    logic        commit;
    logic        wr_commit;
    logic        rd_commit;
    logic [7:0]  word_addr;
    logic        unused_addr0;

    logic [2:0]  ctrl_q,     ctrl_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] reload_q,   reload_d;
    logic [15:0] count_q,    count_d;
    logic [15:0] pcnt_q,     pcnt_d;
    logic        exp_q,      exp_d;
    logic        irq_q;
    logic [15:0] read_q,     read_d;

    logic        tick;
    logic        underflow;
    logic        wr_ctrl, wr_prescale, wr_reload, wr_count, wr_status;
    logic        w1c_exp;

    assign strobe       = uds | lds;
    assign word_addr    = {addr[7:1], 1'b0};
    assign unused_addr0 = addr[0];

    slave_ack_fsm u_ack_fsm (
        .clk      (clk),
        .reset_n  (reset_n),
        .strobe_i (strobe),
        .ack_o    (ack),
        .commit_o (commit)
    );

    assign wr_commit   = commit && !rw;
    assign rd_commit   = commit &&  rw;
    assign wr_ctrl     = wr_commit && (word_addr == REG_CTRL);
    assign wr_prescale = wr_commit && (word_addr == REG_PRESCALE);
    assign wr_reload   = wr_commit && (word_addr == REG_RELOAD);
    assign wr_count    = wr_commit && (word_addr == REG_COUNT);
    assign wr_status   = wr_commit && (word_addr == REG_STATUS);
    assign w1c_exp     = wr_status && lds && write[0];

    assign tick      = ctrl_q[CTRL_EN] && (pcnt_q == prescale_q);
    assign underflow = tick && (count_q == 16'd0);

    // Next-state for registers, prescaler and counter; CPU writes are applied
    // last so they take priority over same-cycle timer updates
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        reload_d   = reload_q;
        count_d    = count_q;
        pcnt_d     = pcnt_q;
        exp_d      = exp_q;

        if (!ctrl_q[CTRL_EN] || tick) begin
            pcnt_d = 16'd0;
        end else begin
            pcnt_d = pcnt_q + 16'd1;
        end

        if (tick) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else if (ctrl_q[CTRL_AUTO]) begin
                count_d = reload_q;
            end else begin
                count_d          = 16'd0;
                ctrl_d[CTRL_EN]  = 1'b0;
            end
        end

        // A set from a fresh underflow outranks the software clear
        if (w1c_exp) begin
            exp_d = 1'b0;
        end
        if (underflow) begin
            exp_d = 1'b1;
        end

        if (wr_ctrl && lds) begin
            ctrl_d = write[2:0];
        end
        if (wr_prescale) begin
            prescale_d = lane_merge(prescale_q, write, uds, lds);
        end
        if (wr_reload) begin
            reload_d = lane_merge(reload_q, write, uds, lds);
        end
        if (wr_count) begin
            count_d = lane_merge(count_q, write, uds, lds);
            pcnt_d  = 16'd0;
        end
    end

    // Read data mux, sampled only on the commit cycle of a read
    always_comb begin
        read_d = read_q;
        if (rd_commit) begin
            case (word_addr)
                REG_CTRL:     read_d = {13'd0, ctrl_q};
                REG_PRESCALE: read_d = prescale_q;
                REG_RELOAD:   read_d = reload_q;
                REG_COUNT:    read_d = count_q;
                REG_STATUS:   read_d = {15'd0, exp_q};
                default:      read_d = 16'd0;
            endcase
        end
    end

    // State registers; irq follows the updated flag and enable together
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_q     <= 3'd0;
            prescale_q <= PRESCALE_RST;
            reload_q   <= RELOAD_RST;
            count_q    <= 16'd0;
            pcnt_q     <= 16'd0;
            exp_q      <= 1'b0;
            irq_q      <= 1'b0;
            read_q     <= 16'd0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            pcnt_q     <= pcnt_d;
            exp_q      <= exp_d;
            irq_q      <= exp_d && ctrl_d[CTRL_IE];
            read_q     <= read_d;
        end
    end

    assign read = read_q;
    assign irq  = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_timer
// Brief   : Self-checking bench for bus_timer: register map, byte lanes,
//           one-shot / auto-reload timing, collisions and handshake timing.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bus_timer;
    import bus_timer_pkg::*;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        rw      = 1'b1;
    logic [7:0]  addr    = 8'h00;
    logic        uds     = 1'b0;
    logic        lds     = 1'b0;
    logic [15:0] wdata   = 16'h0000;
    logic [15:0] rd;
    logic        ack;
    logic        irq;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    bus_timer #(.PRESCALE_RST(16'd0), .RELOAD_RST(16'hFFFF)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rw      (rw),
        .addr    (addr),
        .uds     (uds),
        .lds     (lds),
        .write   (wdata),
        .read    (rd),
        .ack     (ack),
        .irq     (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got=timeout want=finish");
        $fatal(1);
    end

    // Ticks that have occurred at edges start+1..b for a timer started at
    // edge 'start' (one tick every p+1 edges); one-shot stops after c+1
    function automatic int m_ticks(int start, int b, int p, int c, bit auto_m);
        int k;
        if (b <= start) return 0;
        k = (b - start) / (p + 1);
        if (!auto_m && k > c + 1) k = c + 1;
        return k;
    endfunction

    // COUNT after k ticks from initial value c with reload r
    function automatic int m_count(int k, int c, int r, bit auto_m);
        if (k <= c) return c - k;
        if (!auto_m) return 0;
        return r - ((k - c - 1) % (r + 1));
    endfunction

    // Called at a negedge; returns at a negedge with the bus idle
    task automatic xfer(input logic is_rd, input logic [7:0] a, input logic [15:0] d,
                        input logic u, input logic l,
                        output logic [15:0] rdata, output int cedge);
        rw = is_rd; addr = a; wdata = d; uds = u; lds = l;
        cedge = cyc + 1;
        @(negedge clk);
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("FAIL ack_rise addr=%h got=%b want=1", a, ack);
        end
        rdata = rd;
        uds = 1'b0; lds = 1'b0; rw = 1'b1;
        @(negedge clk);
        total++;
        if (ack !== 1'b0 || rd !== rdata) begin
            bad++;
            $display("FAIL ack_fall_read_hold addr=%h got ack=%b rd=%h want ack=0 rd=%h",
                     a, ack, rd, rdata);
        end
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [15:0] d, output int cedge);
        logic [15:0] dummy;
        xfer(1'b0, a, d, 1'b1, 1'b1, dummy, cedge);
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [15:0] v, output int cedge);
        xfer(1'b1, a, 16'h0000, 1'b1, 1'b1, v, cedge);
    endtask

    task automatic wait_until(input int target);
        while (cyc + 1 < target) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; uds = 1'b0; lds = 1'b0; rw = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        logic [15:0] want [5];
        int e;
        want = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        do_reset();
        total++;
        if (ack !== 1'b0 || irq !== 1'b0 || rd !== 16'h0000) begin
            bad++;
            $display("FAIL reset_outputs got ack=%b irq=%b rd=%h want 0 0 0000", ack, irq, rd);
        end
        for (int i = 0; i < 5; i++) begin
            rd_reg(8'(2 * i), v, e);
            total++;
            if (v !== want[i]) begin
                bad++;
                $display("FAIL reset_reg off=%0d got=%h want=%h", 2 * i, v, want[i]);
            end
        end
        rd_reg(8'h05, v, e);
        total++;
        if (v !== 16'hFFFF) begin
            bad++;
            $display("FAIL odd_addr got=%h want=ffff", v);
        end
        wr_reg(8'h0C, 16'h5A5A, e);
        rd_reg(8'h0C, v, e);
        total++;
        if (v !== 16'h0000) begin
            bad++;
            $display("FAIL unmapped got=%h want=0000", v);
        end
    endtask

    // Programs and starts the timer with IE set, then reads it at random
    // moments and compares with the arithmetic model
    task automatic run_timer(input int p, input int c, input int r, input bit auto_m,
                             input int nreads);
        logic [15:0] v, want;
        int e, start, k, sel;
        wr_reg(REG_CTRL, 16'h0000, e);
        wr_reg(REG_PRESCALE, 16'(p), e);
        wr_reg(REG_RELOAD, 16'(r), e);
        wr_reg(REG_COUNT, 16'(c), e);
        wr_reg(REG_STATUS, 16'h0001, e);
        wr_reg(REG_CTRL, {13'd0, 1'b1, auto_m, 1'b1}, start);
        for (int n = 0; n < nreads; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sel = int'($urandom_range(0, 2));
            if (sel == 0) rd_reg(REG_COUNT, v, e);
            else if (sel == 1) rd_reg(REG_STATUS, v, e);
            else rd_reg(REG_CTRL, v, e);
            k = m_ticks(start, e - 1, p, c, auto_m);
            if (sel == 0) want = 16'(m_count(k, c, r, auto_m));
            else if (sel == 1) want = {15'd0, k >= c + 1};
            else want = {13'd0, 1'b1, auto_m, auto_m || (k < c + 1)};
            total++;
            if (v !== want) begin
                bad++;
                $display("FAIL timer_read p=%0d c=%0d r=%0d auto=%0d sel=%0d got=%h want=%h",
                         p, c, r, auto_m, sel, v, want);
            end
            k = m_ticks(start, cyc, p, c, auto_m);
            total++;
            if (irq !== (k >= c + 1)) begin
                bad++;
                $display("FAIL timer_irq p=%0d c=%0d got=%b want=%b", p, c, irq, k >= c + 1);
            end
        end
        if (!auto_m) begin
            wait_until(start + (c + 2) * (p + 1));
            rd_reg(REG_COUNT, v, e);
            total++;
            if (v !== 16'h0000) begin
                bad++;
                $display("FAIL oneshot_count got=%h want=0000", v);
            end
            rd_reg(REG_CTRL, v, e);
            total++;
            if (v !== 16'h0004) begin
                bad++;
                $display("FAIL oneshot_ctrl got=%h want=0004", v);
            end
            total++;
            if (irq !== 1'b1) begin
                bad++;
                $display("FAIL oneshot_irq got=%b want=1", irq);
            end
        end
    endtask

    task automatic test_oneshot();
        run_timer(2, 3, 16'hFFFF, 1'b0, 10);
        for (int i = 0; i < 3; i++)
            run_timer(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 4)), 1'b0, 8);
    endtask

    task automatic test_auto();
        logic [15:0] v;
        int e;
        run_timer(0, 0, 1, 1'b1, 10);
        wr_reg(REG_CTRL, 16'h0004, e);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL auto_irq_before_clear got=%b want=1", irq);
        end
        wr_reg(REG_STATUS, 16'h0001, e);
        rd_reg(REG_STATUS, v, e);
        total++;
        if (v !== 16'h0000 || irq !== 1'b0) begin
            bad++;
            $display("FAIL w1c_clear got status=%h irq=%b want 0000 0", v, irq);
        end
        for (int i = 0; i < 3; i++)
            run_timer(int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 4)), 1'b1, 8);
    endtask

    task automatic test_lanes();
        logic [15:0] v;
        int e;
        do_reset();
        xfer(1'b0, REG_RELOAD, 16'hABCD, 1'b1, 1'b0, v, e);
        rd_reg(REG_RELOAD, v, e);
        total++;
        if (v !== 16'hABFF) begin
            bad++;
            $display("FAIL lane_upper got=%h want=abff", v);
        end
        xfer(1'b0, REG_RELOAD, 16'h1234, 1'b0, 1'b1, v, e);
        rd_reg(REG_RELOAD, v, e);
        total++;
        if (v !== 16'hAB34) begin
            bad++;
            $display("FAIL lane_lower got=%h want=ab34", v);
        end
        xfer(1'b0, REG_CTRL, 16'hFFFF, 1'b1, 1'b0, v, e);
        rd_reg(REG_CTRL, v, e);
        total++;
        if (v !== 16'h0000) begin
            bad++;
            $display("FAIL lane_ctrl_upper got=%h want=0000", v);
        end
    endtask

    task automatic test_collisions();
        logic [15:0] v;
        int e, start, w;
        // COUNT write during a tick (tick every cycle)
        wr_reg(REG_CTRL, 16'h0000, e);
        wr_reg(REG_PRESCALE, 16'h0000, e);
        wr_reg(REG_COUNT, 16'h0100, e);
        wr_reg(REG_CTRL, 16'h0001, start);
        wr_reg(REG_COUNT, 16'h0050, w);
        rd_reg(REG_COUNT, v, e);
        total++;
        if (v !== 16'(32'h50 - (e - 1 - w))) begin
            bad++;
            $display("FAIL count_write_vs_tick got=%h want=%h", v, 16'(32'h50 - (e - 1 - w)));
        end
        // W1C landing on the underflow edge
        wr_reg(REG_CTRL, 16'h0000, e);
        wr_reg(REG_COUNT, 16'h0002, e);
        wr_reg(REG_STATUS, 16'h0001, e);
        wr_reg(REG_CTRL, 16'h0005, start);
        wait_until(start + 3);
        xfer(1'b0, REG_STATUS, 16'h0001, 1'b0, 1'b1, v, e);
        rd_reg(REG_STATUS, v, e);
        total++;
        if (v !== 16'h0001 || irq !== 1'b1) begin
            bad++;
            $display("FAIL w1c_vs_underflow got status=%h irq=%b want 0001 1", v, irq);
        end
        // CTRL write landing on the one-shot expiry edge
        wr_reg(REG_RELOAD, 16'h0005, e);
        wr_reg(REG_COUNT, 16'h0001, e);
        wr_reg(REG_CTRL, 16'h0001, start);
        wait_until(start + 2);
        wr_reg(REG_CTRL, 16'h0003, e);
        rd_reg(REG_CTRL, v, e);
        total++;
        if (v !== 16'h0003) begin
            bad++;
            $display("FAIL ctrl_write_vs_en_clear got=%h want=0003", v);
        end
        wr_reg(REG_CTRL, 16'h0000, e);
    endtask

    task automatic test_hold_and_reset();
        logic [15:0] v;
        int e, start, w;
        wr_reg(REG_PRESCALE, 16'h0000, e);
        wr_reg(REG_COUNT, 16'h0200, e);
        wr_reg(REG_CTRL, 16'h0001, start);
        rw = 1'b0; addr = REG_COUNT; wdata = 16'h0040; uds = 1'b1; lds = 1'b1;
        w = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (ack !== 1'b1) begin
                bad++;
                $display("FAIL hold_ack cycle=%0d got=%b want=1", i + 2, ack);
            end
        end
        uds = 1'b0; lds = 1'b0; rw = 1'b1;
        @(negedge clk);
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL hold_ack_drop got=%b want=0", ack);
        end
        rd_reg(REG_COUNT, v, e);
        total++;
        if (v !== 16'(32'h40 - (e - 1 - w))) begin
            bad++;
            $display("FAIL hold_single_commit got=%h want=%h", v, 16'(32'h40 - (e - 1 - w)));
        end
        // Reset in the middle of a held read, strobe kept through release
        wr_reg(REG_RELOAD, 16'h1357, e);
        rw = 1'b1; addr = REG_RELOAD; uds = 1'b1; lds = 1'b1;
        @(negedge clk);
        total++;
        if (ack !== 1'b1 || rd !== 16'h1357) begin
            bad++;
            $display("FAIL pre_reset_read got ack=%b rd=%h want 1 1357", ack, rd);
        end
        reset_n = 1'b0;
        @(negedge clk);
        total++;
        if (ack !== 1'b0 || rd !== 16'h0000) begin
            bad++;
            $display("FAIL reset_in_ack got ack=%b rd=%h want 0 0000", ack, rd);
        end
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (ack !== 1'b1 || rd !== 16'hFFFF) begin
            bad++;
            $display("FAIL fresh_access got ack=%b rd=%h want 1 ffff", ack, rd);
        end
        uds = 1'b0; lds = 1'b0;
        @(negedge clk);
        rd_reg(REG_COUNT, v, e);
        total++;
        if (v !== 16'h0000) begin
            bad++;
            $display("FAIL post_reset_count got=%h want=0000", v);
        end
        rd_reg(REG_CTRL, v, e);
        total++;
        if (v !== 16'h0000) begin
            bad++;
            $display("FAIL post_reset_ctrl got=%h want=0000", v);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_oneshot();
        test_auto();
        test_lanes();
        test_collisions();
        test_hold_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
